xil_bram_sdp_1clk_init: RTL and testbench
=========================================

// Module: xil_bram_sdp_1clk_init
// PURPOSE
//  Single-clock simple-dual-port RAM wrapper with per-lane byte enables.
//  Adds a self-initialising clear sweep after reset, a programmable read pipeline
//  with a read-valid strobe, and same-cycle write-to-read forwarding.
//  Drop-in RAM for single-clock datapaths (ECC/RS buffers, lookup tables) that
//  need defined content after reset with no external init logic.
// PARAMETERS
//  ADR      10    address width
//  DAT      18    data width; must be divisible by BEN
//  DEP      1024  number of entries; DEP <= 2**ADR
//  BEN      2     byte-enable lanes; lane width LW = DAT/BEN
//  DEL      1     read latency in cycles; legal range 1..3, other values stop elaboration
//  INIT_VAL 0     DAT-bit value written to every entry by the init sweep
// PORTS
//  clk    in   1         clock
//  rst_n  in   1         asynchronous active-low reset
//  wen    in   1         write enable
//  wad    in   ADR       write address
//  wda    in   DAT       write data
//  wbe    in   BEN       write lane enables; lane i covers wda[i*LW +: LW]
//  ren    in   1         read enable
//  rad    in   ADR       read address
//  rdy    out  1         1 = init sweep complete, requests accepted
//  rvl    out  1         read data valid, one pulse per accepted read
//  rda    out  DAT       read data
//  pinj   in   1         parity-error inject; exists only with XIL_BRAM_PARITY_EN
//  perr   out  1         parity error, aligned with rvl; exists only with XIL_BRAM_PARITY_EN
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): rdy=0, rvl=0, rda=0, perr=0. The FSM enters INIT
//    with the sweep counter at 0. All read pipeline stages are flushed.
//  - FSM INIT: while rst_n=1, writes INIT_VAL (all lanes) to the address given by the
//    sweep counter, one address per clock, for addresses 0..DEP-1. After the write to
//    DEP-1, the FSM moves to RUN on the next edge; rdy rises DEP cycles after reset release.
//  - In INIT, wen and ren are ignored: no memory update, no rvl.
//  - FSM RUN: remains in RUN until reset. rdy=1.
//  - Reset mid-sweep or mid-read: the FSM returns to INIT at address 0, and in-flight
//    reads are discarded (no rvl).
//  - Write in RUN: if wen=1 and wad<DEP, lanes with wbe[i]=1 update at the clock edge.
//    If wad>=DEP, the write is dropped.
//  - Read: ren=1 accepted at edge N gives rvl=1 and rda valid at edge N+DEL.
//    Throughput is one read per clock; back-to-back reads produce back-to-back rvl.
//  - Read with rad>=DEP: accepted; rda=0 and rvl=1.
//  - Same-cycle collision (wen & ren, wad==rad, both <DEP): write-first per lane.
//    Enabled lanes return wda; disabled lanes return the old content.
//  - A read snapshots the content as of its issue edge, including the collision merge.
//    Writes issued after the read do not alter its in-flight data.
//  - rda holds its last value while rvl=0. rvl is never asserted while rdy=0.
// CONFIGURATION
//  Macro XIL_BRAM_PARITY_EN:
//  - Defined: one even-parity bit is stored per lane, so memory width is DAT+BEN.
//    - The init sweep writes correct parity.
//    - pinj=1 on a write inverts the stored parity of the written lanes.
//    - On read, perr=1 in the rvl cycle if any lane mismatches; perr=0 otherwise.
//    - perr is not checked for rad>=DEP.
//  - Undefined: ports pinj and perr do not exist, no parity storage, memory width is DAT.
// TESTING
//  T1 DEP=16, release reset: rdy=0 for exactly 16 cycles, then 1. Reading addrs 0..15
//     returns INIT_VAL; any wen/ren issued during INIT gives no rvl and no change.
//  T2 DEL=1,2,3: write 0x155AA to addr 5, then ren addr 5 at edge N ->
//     rvl=1 at N+DEL only, rda=0x155AA.
//  T3 BEN=2, DAT=18: addr 3 holds 0x3FFFF; same-cycle wen wbe=2'b01 wda=0x00000 with ren
//     addr 3 -> rda=0x3FE00. A later read of addr 3 also returns 0x3FE00.
//  T4 Burst ren addrs 0..7 back-to-back with wen to addr 2 one cycle after its read ->
//     8 consecutive rvl pulses; addr 2 returns its pre-write value.
//  T5 Pull rst_n low mid-burst, with 2 reads in flight -> rvl=0 immediately and the
//     in-flight reads are never delivered. The full init sweep re-runs, and reads
//     return INIT_VAL.
//  T6 (XIL_BRAM_PARITY_EN) write addr 7 with pinj=1, then read addr 7 -> perr=1 with rvl.
//     Rewrite addr 7 with pinj=0, then read -> perr=0. Read addr 20 (DEP=16) -> rda=0, perr=0.

Source files
------------

// File: rtl/xil_bram_sdp_1clk_init.sv
// Single-clock simple-dual-port RAM with lane enables, post-reset clear sweep,
// 1..3 cycle read pipeline and write-first collision merge. Parity: XIL_BRAM_PARITY_EN.
module xil_bram_sdp_1clk_init #(
  parameter int unsigned    ADR      = 10,
  parameter int unsigned    DAT      = 18,
  parameter int unsigned    DEP      = 1024,
  parameter int unsigned    BEN      = 2,
  parameter int unsigned    DEL      = 1,
  parameter logic [DAT-1:0] INIT_VAL = '0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           wen,
  input  logic [ADR-1:0] wad,
  input  logic [DAT-1:0] wda,
  input  logic [BEN-1:0] wbe,
  input  logic           ren,
  input  logic [ADR-1:0] rad,
`ifdef XIL_BRAM_PARITY_EN
  input  logic           pinj,
  output logic           perr,
`endif
  output logic           rdy,
  output logic           rvl,
  output logic [DAT-1:0] rda
);

  localparam int unsigned LW = DAT / BEN;
  localparam int unsigned AW = (DEP > 1) ? $clog2(DEP) : 1;
`ifdef XIL_BRAM_PARITY_EN
  localparam int unsigned MW = DAT + BEN;
`else
  localparam int unsigned MW = DAT;
`endif
  localparam logic [ADR:0] DEP_W = (ADR + 1)'(DEP);

  if (DEL < 1 || DEL > 3) begin : g_del_chk
    $error("DEL must be in 1..3");
  end
  if (DAT % BEN != 0) begin : g_ben_chk
    $error("DAT must be divisible by BEN");
  end

  typedef enum logic {StInit, StRun} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == StInit) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(DEP - 1)) begin
        state_d = StRun;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rdy = (state_q == StRun);

  logic          wad_ok, rad_ok, wr_ok, rd_acc;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [BEN-1:0] mem_be;
  logic [MW-1:0] mem_wd, init_word, wr_word, rd_word;
  logic          rd_err;

  assign wad_ok = ({1'b0, wad} < DEP_W);
  assign rad_ok = ({1'b0, rad} < DEP_W);
  assign wr_ok  = rdy & wen & wad_ok;
  assign rd_acc = rdy & ren;

  // Stored word = data, then one even-parity bit per lane when parity is built in.
  always_comb begin
    init_word            = '0;
    wr_word              = '0;
    init_word[DAT-1:0]   = INIT_VAL;
    wr_word[DAT-1:0]     = wda;
`ifdef XIL_BRAM_PARITY_EN
    for (int i = 0; i < BEN; i++) begin
      init_word[DAT+i] = ^INIT_VAL[i*LW +: LW];
      wr_word[DAT+i]   = (^wda[i*LW +: LW]) ^ pinj;
    end
`endif
  end

  always_comb begin
    mem_we = wr_ok;
    mem_wa = wad[AW-1:0];
    mem_be = wbe;
    mem_wd = wr_word;
    if (state_q == StInit) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_be = '1;
      mem_wd = init_word;
    end
  end

  logic [MW-1:0] mem [DEP];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < BEN; i++) begin
        if (mem_be[i]) begin
          mem[mem_wa][i*LW +: LW] <= mem_wd[i*LW +: LW];
`ifdef XIL_BRAM_PARITY_EN
          mem[mem_wa][DAT+i] <= mem_wd[DAT+i];
`endif
        end
      end
    end
  end

  // Read snapshot at the issue edge; a same-address write wins on its enabled lanes.
  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    if (rad_ok) begin
      rd_word = mem[rad[AW-1:0]];
      if (wr_ok && (wad == rad)) begin
        for (int i = 0; i < BEN; i++) begin
          if (wbe[i]) begin
            rd_word[i*LW +: LW] = wr_word[i*LW +: LW];
`ifdef XIL_BRAM_PARITY_EN
            rd_word[DAT+i] = wr_word[DAT+i];
`endif
          end
        end
      end
`ifdef XIL_BRAM_PARITY_EN
      for (int i = 0; i < BEN; i++) begin
        rd_err = rd_err | ((^rd_word[i*LW +: LW]) ^ rd_word[DAT+i]);
      end
`endif
    end
  end

  // Each stage only loads on valid, so the last stage holds rda while rvl is low.
  logic [DEL-1:0] v_q;
  logic [DAT-1:0] d_q [DEL];
`ifdef XIL_BRAM_PARITY_EN
  logic [DEL-1:0] e_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int i = 0; i < DEL; i++) d_q[i] <= '0;
`ifdef XIL_BRAM_PARITY_EN
      e_q <= '0;
`endif
    end else begin
      v_q[0] <= rd_acc;
      if (rd_acc) begin
        d_q[0] <= rd_word[DAT-1:0];
`ifdef XIL_BRAM_PARITY_EN
        e_q[0] <= rd_err;
`endif
      end
      for (int i = 1; i < DEL; i++) begin
        v_q[i] <= v_q[i-1];
        if (v_q[i-1]) begin
          d_q[i] <= d_q[i-1];
`ifdef XIL_BRAM_PARITY_EN
          e_q[i] <= e_q[i-1];
`endif
        end
      end
    end
  end

  assign rvl = v_q[DEL-1];
  assign rda = d_q[DEL-1];
`ifdef XIL_BRAM_PARITY_EN
  assign perr = v_q[DEL-1] & e_q[DEL-1];
`else
  logic unused_rd;
  assign unused_rd = rd_err;
`endif

endmodule

// File: tb/tb_xil_bram_sdp_1clk_init.sv
// Scoreboard bench for xil_bram_sdp_1clk_init: DEP=16, DAT=18, BEN=2, DEL set by parameter.
module tb_xil_bram_sdp_1clk_init;
  parameter int unsigned DEL = 2;
  localparam int unsigned ADR = 5;
  localparam int unsigned DAT = 18;
  localparam int unsigned DEP = 16;
  localparam int unsigned BEN = 2;
  localparam int unsigned LW  = DAT / BEN;
  localparam logic [DAT-1:0] INIT_VAL = 18'h0A5C3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wen = 1'b0, ren = 1'b0;
  logic [ADR-1:0] wad = '0, rad = '0;
  logic [DAT-1:0] wda = '0;
  logic [BEN-1:0] wbe = '0;
  logic           rdy, rvl;
  logic [DAT-1:0] rda;
`ifdef XIL_BRAM_PARITY_EN
  logic           pinj = 1'b0;
  logic           perr;
`endif

  xil_bram_sdp_1clk_init #(
    .ADR(ADR), .DAT(DAT), .DEP(DEP), .BEN(BEN), .DEL(DEL), .INIT_VAL(INIT_VAL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .wen  (wen),
    .wad  (wad),
    .wda  (wda),
    .wbe  (wbe),
    .ren  (ren),
    .rad  (rad),
`ifdef XIL_BRAM_PARITY_EN
    .pinj (pinj),
    .perr (perr),
`endif
    .rdy  (rdy),
    .rvl  (rvl),
    .rda  (rda)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DAT-1:0] data;
    logic           err;
    int             cyc;
  } exp_t;

  exp_t           sb[$];
  logic [DAT-1:0] model [DEP];
  logic [BEN-1:0] minj  [DEP];
  bit             model_run;
  int             sw, cyc;
  int             n_chk, n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Drives one clock of stimulus; the expected read result is pushed before the edge.
  task automatic step(input logic w, input logic [ADR-1:0] wa, input logic [DAT-1:0] wd,
                      input logic [BEN-1:0] be, input logic r, input logic [ADR-1:0] ra,
                      input logic pj);
    exp_t           e;
    logic [BEN-1:0] inj;
    wen = w; wad = wa; wda = wd; wbe = be; ren = r; rad = ra;
`ifdef XIL_BRAM_PARITY_EN
    pinj = pj;
`endif
    if (model_run && r) begin
      e.data = '0;
      e.err  = 1'b0;
      e.cyc  = cyc + 1;
      if (ra < DEP) begin
        e.data = model[ra];
        inj    = minj[ra];
        if (w && wa == ra) begin
          for (int l = 0; l < BEN; l++) begin
            if (be[l]) begin
              e.data[l*LW +: LW] = wd[l*LW +: LW];
              inj[l] = pj;
            end
          end
        end
        e.err = |inj;
      end
      sb.push_back(e);
    end
    if (model_run && w && wa < DEP) begin
      for (int l = 0; l < BEN; l++) begin
        if (be[l]) begin
          model[wa][l*LW +: LW] = wd[l*LW +: LW];
          minj[wa][l] = pj;
        end
      end
    end
    @(posedge clk);
    cyc++;
    if (!model_run) begin
      sw++;
      if (sw == DEP) model_run = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // Asserts reset mid-cycle so any in-flight read is cut off asynchronously.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rvl", rvl, 0);
    check("rst_rda", rda, 0);
    check("rst_rdy", rdy, 0);
`ifdef XIL_BRAM_PARITY_EN
    check("rst_perr", perr, 0);
`endif
    sb.delete();
    model_run = 1'b0;
    sw = 0;
    for (int a = 0; a < DEP; a++) begin
      model[a] = INIT_VAL;
      minj[a]  = '0;
    end
    wen = 1'b0; ren = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Sweep phase with writes and reads hammering; none may take effect.
  task automatic init_sweep();
    for (int k = 0; k < DEP; k++) begin
      check("rdy_init", rdy, 0);
      step(1'b1, ADR'(k), 18'h3FFFF, 2'b11, 1'b1, ADR'(k), 1'b1);
    end
    check("rdy_run", rdy, 1);
    for (int a = 0; a < DEP; a++) step(1'b0, '0, '0, '0, 1'b1, ADR'(a), 1'b0);
    idle(DEL + 1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rvl) begin
        if (sb.size() == 0) begin
          check("rvl_spurious", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rda", rda, e.data);
          check("rvl_latency", cyc, e.cyc + DEL - 1);
`ifdef XIL_BRAM_PARITY_EN
          check("perr", perr, e.err);
`endif
        end
      end else if (sb.size() > 0 && sb[0].cyc + DEL - 1 < cyc) begin
        check("rvl_missing", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0;
    @(negedge clk);
    do_reset();
    init_sweep();

    // Plain write then read.
    step(1'b1, 5'd5, 18'h155AA, 2'b11, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 5'd5, 1'b0);
    idle(DEL + 1);

    // Collision, lane 0 written, lane 1 old content; then re-read.
    step(1'b1, 5'd3, 18'h3FFFF, 2'b11, 1'b0, '0, 1'b0);
    step(1'b1, 5'd3, 18'h00000, 2'b01, 1'b1, 5'd3, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 5'd3, 1'b0);
    idle(DEL + 1);

    // Burst with a write to addr 2 one cycle after its read; then re-read addr 2.
    for (int a = 0; a < 8; a++) step(a == 3, 5'd2, 18'h12345, 2'b11, 1'b1, ADR'(a), 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 5'd2, 1'b0);
    idle(DEL + 1);

    // Out-of-range write dropped, out-of-range read returns zero.
    step(1'b1, 5'd20, 18'h2AAAA, 2'b11, 1'b1, 5'd20, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 5'd4, 1'b0);
    idle(DEL + 1);

`ifdef XIL_BRAM_PARITY_EN
    step(1'b1, 5'd7, 18'h0F0F0, 2'b11, 1'b0, '0, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 5'd7, 1'b0);
    step(1'b1, 5'd7, 18'h0F0F0, 2'b11, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 5'd7, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 5'd20, 1'b0);
    idle(DEL + 1);
`endif

    // Random traffic including out-of-range addresses and collisions.
    for (int i = 0; i < 80; i++) begin
      logic [ADR-1:0] wa, ra;
      wa = ADR'($urandom_range(0, 19));
      ra = ($urandom_range(0, 3) == 0) ? wa : ADR'($urandom_range(0, 19));
      step(1'($urandom), wa, DAT'($urandom), BEN'($urandom), 1'($urandom), ra,
           ($urandom_range(0, 4) == 0));
    end
    idle(DEL + 1);

    // Reset in the middle of a burst; the sweep must run again.
    for (int a = 0; a < 4; a++) step(1'b0, '0, '0, '0, 1'b1, ADR'(a + 8), 1'b0);
    do_reset();
    init_sweep();

    idle(DEL + 2);
    check("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
